// File: rtl/wb_mem_responder_if.sv
// Wishbone pipelined request/response bundle between a bus master and wb_mem_responder.
interface wb_mem_responder_if #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 128
);
   logic                   i_wb_cyc;
   logic                   i_wb_stb;
   logic                   i_wb_we;
   logic [ADDR_BITS-1:0]   i_wb_addr;
   logic [DATA_BITS-1:0]   i_wb_data;
   logic [DATA_BITS/8-1:0] i_wb_sel;
   logic                   i_aux;
   logic                   o_wb_stall;
   logic                   o_wb_ack;
   logic [DATA_BITS-1:0]   o_wb_data;
   logic                   o_aux;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
      output o_wb_stall, o_wb_ack, o_wb_data, o_aux
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel, i_aux,
      input  o_wb_stall, o_wb_ack, o_wb_data, o_aux
   );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone memory responder with fixed ack latency, init stall and optional refresh windows.
// Define WB_MEM_RESPONDER_REFRESH_EN to build the periodic refresh emulation.
module wb_mem_responder #(
   parameter int ADDR_BITS       = 24,
   parameter int DATA_BITS       = 128,
   parameter int DEPTH_BITS      = 10,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int INIT_CYCLES     = 64,
   parameter int REFRESH_PERIOD  = 1024,
   parameter int REFRESH_CYCLES  = 16
) (
   input logic               clk,
   input logic               rst_n,
   wb_mem_responder_if.slave bus
);
   localparam int SEL_BITS = DATA_BITS / 8;
   localparam int DEPTH    = 1 << DEPTH_BITS;
   localparam int LAST     = LATENCY - 1;
   localparam int WAIT_MAX = (INIT_CYCLES > REFRESH_CYCLES) ? INIT_CYCLES : REFRESH_CYCLES;
   localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

`ifdef WB_MEM_RESPONDER_REFRESH_EN
   typedef enum logic [1:0] {S_INIT, S_RUN, S_REFRESH} state_t;
   localparam int REF_W = $clog2(REFRESH_PERIOD) + 1;
   logic [REF_W-1:0] r_ref_cnt, w_ref_cnt_nxt;
`else
   typedef enum logic [1:0] {S_INIT, S_RUN} state_t;
   localparam int unused_refresh_period = REFRESH_PERIOD;
`endif

   logic [DATA_BITS-1:0]  r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] w_idx;
   logic                  w_accept;
   logic                  w_ack;
   logic                  w_full;
   logic                  w_stall;
   logic                  w_unused_addr;

   state_t                r_state, w_state_nxt;
   logic [WAIT_W-1:0]     r_wait_cnt, w_wait_cnt_nxt;
   logic [3:0]            r_out_cnt;

   logic                  r_vld_p  [LATENCY];
   logic                  r_we_p   [LATENCY];
   logic                  r_aux_p  [LATENCY];
   logic [DATA_BITS-1:0]  r_data_p [LATENCY];
   logic                  w_vld_in [LATENCY];
   logic                  w_we_in  [LATENCY];
   logic                  w_aux_in [LATENCY];
   logic [DATA_BITS-1:0]  w_data_in[LATENCY];
   logic [DATA_BITS-1:0]  r_rdata;

   assign w_idx         = bus.i_wb_addr[DEPTH_BITS-1:0];
   assign w_unused_addr = ^bus.i_wb_addr[ADDR_BITS-1:DEPTH_BITS];
   assign w_ack         = r_vld_p[LAST];
   assign w_full        = (r_out_cnt == 4'(MAX_OUTSTANDING));
   assign w_accept      = bus.i_wb_cyc && bus.i_wb_stb && !w_stall;

   assign bus.o_wb_stall = w_stall;
   assign bus.o_wb_ack   = w_ack;
   assign bus.o_wb_data  = r_rdata;
   assign bus.o_aux      = w_ack & r_aux_p[LAST];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_wait_cnt <= '0;
`ifdef WB_MEM_RESPONDER_REFRESH_EN
         r_ref_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
`ifdef WB_MEM_RESPONDER_REFRESH_EN
         r_ref_cnt  <= w_ref_cnt_nxt;
`endif
      end
   end

   // The wait counter times both the INIT stall and each refresh window.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_stall        = 1'b1;
`ifdef WB_MEM_RESPONDER_REFRESH_EN
      w_ref_cnt_nxt  = r_ref_cnt;
`endif
      case (r_state)
         S_INIT: begin
            if (r_wait_cnt == WAIT_W'(INIT_CYCLES - 1)) begin
               w_state_nxt    = S_RUN;
               w_wait_cnt_nxt = '0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         S_RUN: begin
            w_stall = w_full && !w_ack;
`ifdef WB_MEM_RESPONDER_REFRESH_EN
            if (r_ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
               w_ref_cnt_nxt = '0;
               w_state_nxt   = S_REFRESH;
            end else begin
               w_ref_cnt_nxt = r_ref_cnt + REF_W'(1);
            end
`endif
         end
`ifdef WB_MEM_RESPONDER_REFRESH_EN
         S_REFRESH: begin
            if (r_wait_cnt == WAIT_W'(REFRESH_CYCLES - 1)) begin
               w_state_nxt    = S_RUN;
               w_wait_cnt_nxt = '0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
`endif
         default: begin
            w_state_nxt    = S_INIT;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   // Writes land at acceptance; storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_accept && bus.i_wb_we) begin
         for (int b = 0; b < SEL_BITS; b++) begin
            if (bus.i_wb_sel[b]) r_mem[w_idx][8*b +: 8] <= bus.i_wb_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_cnt <= '0;
      end else if (!bus.i_wb_cyc) begin
         r_out_cnt <= '0;
      end else if (w_accept && !w_ack) begin
         r_out_cnt <= r_out_cnt + 4'd1;
      end else if (!w_accept && w_ack) begin
         r_out_cnt <= r_out_cnt - 4'd1;
      end
   end

   // Stage 0 takes the request and the storage read; dropping cyc empties every stage.
   always_comb begin
      w_vld_in[0]  = w_accept;
      w_we_in[0]   = bus.i_wb_we;
      w_aux_in[0]  = bus.i_aux;
      w_data_in[0] = r_mem[w_idx];
      for (int k = 1; k < LATENCY; k++) begin
         w_vld_in[k]  = bus.i_wb_cyc && r_vld_p[k-1];
         w_we_in[k]   = r_we_p[k-1];
         w_aux_in[k]  = r_aux_p[k-1];
         w_data_in[k] = r_data_p[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < LATENCY; k++) r_vld_p[k] <= 1'b0;
      end else begin
         for (int k = 0; k < LATENCY; k++) r_vld_p[k] <= w_vld_in[k];
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LATENCY; k++) begin
         r_we_p[k]  <= w_we_in[k];
         r_aux_p[k] <= w_aux_in[k];
         if (k < LAST) r_data_p[k] <= w_data_in[k];
      end
   end

   // Output data only moves on a read entering the ack stage, so it holds otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (w_vld_in[LAST] && !w_we_in[LAST]) begin
         r_rdata <= w_data_in[LAST];
      end
   end
endmodule
